fifo8_stream_adapter: RTL and testbench

//  Front-end controller for the 8-entry FIFO_8 block (ports wen/ren/din/dout/error).

---
 rtl/fifo8_stream_adapter_pkg.sv | 23 ++
 rtl/fifo8_out_buf.sv | 52 +++++
 rtl/fifo8_stream_adapter.sv | 124 ++++++++++++
 tb/tb_fifo8_stream_adapter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo8_stream_adapter_pkg.sv
// Shared constants and helpers for the FIFO_8 stream adapter.
package fifo8_stream_adapter_pkg;

  // Defaults matching the FIFO_8 block
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int LEVEL_W   = 4;

  // Arbiter priority encoding
  localparam logic [0:0] PRIO_WRITE = 1'b0;
  localparam logic [0:0] PRIO_READ  = 1'b1;

  // True when a new read may be launched: data already buffered plus data in
  // flight from FIFO_8, minus the entry leaving this cycle, must leave a free slot.
  function automatic logic has_credit(input logic [1:0] obuf_cnt,
                                      input logic       inflight,
                                      input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    return (pending < 3'd2);
  endfunction

endpackage

// File: rtl/fifo8_out_buf.sv
// Two-entry circular output buffer absorbing FIFO_8 read latency.
// A pop and a push in the same cycle are legal; the pop is logically first.
module fifo8_out_buf
  import fifo8_stream_adapter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       cnt_r;

  // Storage: capture pushed data at the write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (push) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push) wr_ptr_r <= ~wr_ptr_r;
      if (pop)  rd_ptr_r <= ~rd_ptr_r;
      case ({push, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign cnt       = cnt_r;
  assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo8_stream_adapter.sv
// Valid/ready front-end for FIFO_8: shadows its occupancy, arbitrates wen/ren
// so FIFO_8 never sees an illegal access, and hides its read latency.
module fifo8_stream_adapter
  import fifo8_stream_adapter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_data,
  output logic               fifo_wen,
  output logic               fifo_ren,
  output logic [WIDTH-1:0]   fifo_din,
  input  logic [WIDTH-1:0]   fifo_dout,
  input  logic               fifo_error,
  output logic [LEVEL_W-1:0] level,
  output logic               err_sticky
);

  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);

  logic [LEVEL_W-1:0] count_r;
  logic               inflight_r;
  logic [0:0]         prio_r;
  logic               err_sticky_r;

  logic [1:0]         obuf_cnt_s;
  logic [WIDTH-1:0]   obuf_head_s;
  logic               m_valid_s;
  logic               pop_s;
  logic               credit_s;
  logic               not_full_s;
  logic               not_empty_s;
  logic               wr_want_s;
  logic               rd_want_s;
  logic               contested_s;
  logic               s_ready_s;
  logic               wen_s;
  logic               ren_s;

  // Wants, arbitration and handshake decode
  always_comb begin
    m_valid_s   = (obuf_cnt_s != 2'd0);
    pop_s       = m_valid_s & m_ready;
    credit_s    = has_credit(obuf_cnt_s, inflight_r, pop_s);
    not_full_s  = (count_r < DEPTH_L);
    not_empty_s = (count_r != {LEVEL_W{1'b0}});
    wr_want_s   = s_valid & not_full_s;
    rd_want_s   = not_empty_s & credit_s;
    contested_s = wr_want_s & rd_want_s;
    // s_ready never looks at s_valid, so the producer sees no combinational loop
    s_ready_s   = not_full_s & ~(rd_want_s & (prio_r == PRIO_READ));
    wen_s       = s_valid & s_ready_s;
    ren_s       = rd_want_s & ~wen_s;
  end

  // Shadow occupancy of FIFO_8
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {LEVEL_W{1'b0}};
    end else begin
      case ({wen_s, ren_s})
        2'b10:   count_r <= count_r + {{(LEVEL_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(LEVEL_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Read-in-flight marker: FIFO_8 dout is valid one cycle after ren
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= ren_s;
    end
  end

  // Round-robin priority, flipped only when both sides competed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= PRIO_WRITE;
    end else if (contested_s) begin
      prio_r <= ~prio_r;
    end
  end

  // Sticky record of any FIFO_8 error, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
    end else begin
      err_sticky_r <= err_sticky_r | fifo_error;
    end
  end

  fifo8_out_buf #(
    .WIDTH (WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_r),
    .push_data (fifo_dout),
    .pop       (pop_s),
    .cnt       (obuf_cnt_s),
    .head_data (obuf_head_s)
  );

  assign s_ready    = s_ready_s;
  assign fifo_wen   = wen_s;
  assign fifo_ren   = ren_s;
  assign fifo_din   = s_data;
  assign m_valid    = m_valid_s;
  assign m_data     = obuf_head_s;
  assign level      = count_r;
  assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_fifo8_stream_adapter.sv
// Self-checking bench: FIFO_8 behavioural model, stream scoreboard,
// table-driven fill sequence, directed corner cases and random traffic.
module tb_fifo8_stream_adapter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       fifo_wen;
  logic       fifo_ren;
  logic [7:0] fifo_din;
  logic [7:0] fifo_dout;
  logic       fifo_error;
  logic [3:0] level;
  logic       err_sticky;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo8_stream_adapter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .fifo_wen   (fifo_wen),
    .fifo_ren   (fifo_ren),
    .fifo_din   (fifo_din),
    .fifo_dout  (fifo_dout),
    .fifo_error (fifo_error),
    .level      (level),
    .err_sticky (err_sticky)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO_8 behavioural model ----------------
  logic [7:0] fmem [8];
  int         fcnt;
  int         fwp;
  int         frp;
  logic       model_err;
  logic       inject = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= 0; fwp <= 0; frp <= 0; model_err <= 1'b0; fifo_dout <= 8'd0;
    end else begin
      model_err <= 1'b0;
      if (fifo_wen && fifo_ren) model_err <= 1'b1;
      else if (fifo_wen) begin
        if (fcnt == 8) model_err <= 1'b1;
        else begin fmem[fwp] <= fifo_din; fwp <= (fwp + 1) % 8; fcnt <= fcnt + 1; end
      end else if (fifo_ren) begin
        if (fcnt == 0) model_err <= 1'b1;
        else begin fifo_dout <= fmem[frp]; frp <= (frp + 1) % 8; fcnt <= fcnt - 1; end
      end
    end
  end
  assign fifo_error = model_err | inject;

  // ---------------- Stream scoreboard and invariants ----------------
  logic [7:0] sb [$];
  logic [7:0] popped [$];
  int         wen_n = 0;
  int         ren_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("wen_ren_exclusive", {31'd0, fifo_wen & fifo_ren}, 32'd0);
      chk("wen_is_handshake", {31'd0, fifo_wen}, {31'd0, s_valid & s_ready});
      chk("level_vs_fifo8", {28'd0, level}, fcnt);
      chk("fifo8_no_error", {31'd0, model_err}, 32'd0);
      if (fifo_wen) wen_n++;
      if (fifo_ren) ren_n++;
      if (s_valid && s_ready) sb.push_back(s_data);
      if (m_valid && m_ready) begin
        popped.push_back(m_data);
        if (sb.size() == 0) chk("pop_without_beat", 32'd1, 32'd0);
        else chk("m_data_order", {24'd0, m_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (30) cyc();
    chk("drain_level", {28'd0, level}, 32'd0);
    chk("drain_m_valid", {31'd0, m_valid}, 32'd0);
    chk("drain_scoreboard_empty", sb.size(), 32'd0);
  endtask

  // ---------------- Fill table ----------------
  typedef struct {
    logic       sv;
    logic       mr;
    logic       e_sready;
    logic       e_ren;
    logic [3:0] e_level;
    logic       e_mvalid;
  } vec_t;

  vec_t       fill_tab [14];
  logic [7:0] offer [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int t;
    logic hs;

    offer = '{8'd56, 8'd11, 8'd42, 8'd10, 8'd23, 8'd20, 8'd6, 8'd85, 8'd45, 8'd12, 8'd77};
    //               sv    mr    s_ready ren   level  m_valid
    fill_tab[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    fill_tab[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0};
    fill_tab[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    fill_tab[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0};
    fill_tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1};
    fill_tab[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1};
    fill_tab[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1};
    fill_tab[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1};
    fill_tab[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1};
    fill_tab[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1};
    fill_tab[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1};
    fill_tab[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 1'b1};
    fill_tab[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1};
    fill_tab[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1};

    // 1: reset state
    repeat (2) @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_fifo_wen", {31'd0, fifo_wen}, 32'd0);
    chk("rst_fifo_ren", {31'd0, fifo_ren}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2: fill with consumer stalled
    idx = 0;
    for (int i = 0; i < 14; i++) begin
      s_valid = fill_tab[i].sv;
      m_ready = fill_tab[i].mr;
      s_data  = offer[(idx > 10) ? 10 : idx];
      @(negedge clk);
      chk("fill_s_ready", {31'd0, s_ready}, {31'd0, fill_tab[i].e_sready});
      chk("fill_fifo_ren", {31'd0, fifo_ren}, {31'd0, fill_tab[i].e_ren});
      chk("fill_level", {28'd0, level}, {28'd0, fill_tab[i].e_level});
      chk("fill_m_valid", {31'd0, m_valid}, {31'd0, fill_tab[i].e_mvalid});
      hs = s_valid & s_ready;
      cyc();
      if (hs) idx++;
    end
    chk("fill_accepted", idx, 32'd10);
    chk("fill_level_full", {28'd0, level}, 32'd8);
    chk("fill_obuf_head", {24'd0, m_data}, 32'd56);
    chk("fill_err_sticky", {31'd0, err_sticky}, 32'd0);

    // 3: drain while still offering 77
    popped.delete();
    m_ready = 1'b1;
    s_data  = offer[10];
    t = 0;
    while (popped.size() < 11 && t < 200) begin cyc(); t++; end
    chk("drain_progress", {31'd0, popped.size() >= 11}, 32'd1);
    for (int i = 0; i < 11; i++)
      if (i < popped.size()) chk("drain_sequence", {24'd0, popped[i]}, {24'd0, offer[i]});
    drain();

    // 4: sustained contention
    wen_n = 0; ren_n = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_data = 8'($urandom);
      cyc();
    end
    chk("contend_writes", {31'd0, wen_n >= 15}, 32'd1);
    chk("contend_reads", {31'd0, ren_n >= 15}, 32'd1);
    drain();

    // random traffic against scoreboard and FIFO_8 model
    for (int i = 0; i < 400; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      cyc();
    end
    drain();

    // 5: latency of a single beat into an empty system
    m_ready = 1'b0; s_valid = 1'b1; s_data = 8'hA5;
    @(negedge clk);
    chk("lat_accept", {31'd0, s_ready}, 32'd1);
    cyc();                                   // E0
    s_valid = 1'b0;
    @(negedge clk);
    chk("lat_ren_after_e0", {31'd0, fifo_ren}, 32'd1);
    chk("lat_mvalid_e0", {31'd0, m_valid}, 32'd0);
    cyc();                                   // E1
    chk("lat_mvalid_e1", {31'd0, m_valid}, 32'd0);
    cyc();                                   // E2
    chk("lat_mvalid_e2", {31'd0, m_valid}, 32'd1);
    chk("lat_mdata_e2", {24'd0, m_data}, 32'hA5);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;

    // 6: sticky error, then reset mid-operation
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    chk("err_set", {31'd0, err_sticky}, 32'd1);
    repeat (5) cyc();
    chk("err_held", {31'd0, err_sticky}, 32'd1);
    s_valid = 1'b1;
    t = 0;
    while (level != 4'd5 && t < 50) begin s_data = 8'($urandom); cyc(); t++; end
    s_valid = 1'b0;
    chk("pre_reset_level", {28'd0, level}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", {28'd0, level}, 32'd0);
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("arst_fifo_ren", {31'd0, fifo_ren}, 32'd0);
    cyc();
    rst_n = 1'b1;
    popped.delete();
    s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    t = 0;
    while (popped.size() < 1 && t < 20) begin cyc(); t++; end
    chk("post_reset_progress", popped.size(), 32'd1);
    if (popped.size() > 0) chk("post_reset_first", {24'd0, popped[0]}, 32'h3C);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
